dht_reader: RTL

//  Parametrised single-wire reader for the DHT22/AM2302 sensor family (DHT11 via params).

---
 rtl/dht_reader.sv | 329 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dht_reader.sv
`default_nettype none
// ============================================================================
// Module   : dht_reader
// Purpose  : Single-wire reader for the DHT22/AM2302 sensor family (DHT11 via
//            parameters). Generates the host start pulse on an open-drain
//            line, follows the sensor response handshake, decodes NBITS
//            pulse-width encoded bits (MSB first), validates the checksum and
//            enforces a hold-off period before the next read is accepted.
// Ports    : clk      - clock
//            reset    - synchronous, active-high reset
//            get      - start request, accepted only while idle
//            sda      - open-drain sensor line, driven 0 or released (Z)
//            data     - last frame that passed validation
//            valid    - 1-cycle pulse, data has just been updated
//            error    - 1-cycle pulse, read failed
//            err_code - 1 no response, 2 bit timeout, 3 checksum; held until
//                       the next completion (0 after a good read)
//            busy     - high from get acceptance until the hold-off expires
// Revision : 1.0 - initial release
// ============================================================================
module dht_reader #(
    parameter int CLK_HZ        = 1_000_000,
    parameter int START_LOW_US  = 1000,
    parameter int TIMEOUT_US    = 100,
    parameter int BIT_THRESH_US = 48,
    parameter int NBITS         = 40,
    parameter int CHECKSUM_EN   = 1,
    parameter int HOLDOFF_US    = 2_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             get,
    inout  wire              sda,
    output logic [NBITS-1:0] data,
    output logic             valid,
    output logic             error,
    output logic [1:0]       err_code,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_TICK_DIV = CLK_HZ / 1_000_000;
    localparam int c_BIT_W    = $clog2(NBITS + 1);

    localparam logic [1:0] c_ERR_NORESP = 2'd1;
    localparam logic [1:0] c_ERR_BITTO  = 2'd2;
    localparam logic [1:0] c_ERR_CSUM   = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_START     = 4'd1,
        S_RELEASE   = 4'd2,
        S_RESP_LOW  = 4'd3,
        S_RESP_HIGH = 4'd4,
        S_BIT_LOW   = 4'd5,
        S_BIT_HIGH  = 4'd6,
        S_CHECK     = 4'd7,
        S_FAIL      = 4'd8,
        S_HOLD      = 4'd9
    } state_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    state_t                r_state;
    state_t                w_next;

    logic [31:0]           r_div;
    logic                  w_tick;
    logic [31:0]           r_cnt;
    logic [31:0]           w_elapsed;

    logic                  r_sda_meta;
    logic                  r_sda_sync;
    logic                  r_drive;
    logic                  r_seen_high;

    logic [NBITS-1:0]      r_shift;
    logic [c_BIT_W-1:0]    r_bitcnt;
    logic [1:0]            r_fail_code;

    logic                  w_bit;
    logic                  w_shift_en;
    logic                  w_fail_load;
    logic [1:0]            w_fail_code;
    logic                  w_ok;
    logic                  w_err;
    logic                  w_sum_ok;

    // ------------------------------------------------------------------------
    // Open-drain output: only ever pull low or release.
    // ------------------------------------------------------------------------
    assign sda  = r_drive ? 1'b0 : 1'bz;
    assign busy = (r_state != S_IDLE);

    // ------------------------------------------------------------------------
    // Free-running microsecond tick
    // ------------------------------------------------------------------------
    assign w_tick = (r_div == 32'(c_TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 32'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Two-flop synchroniser; the line idles high through the pull-up.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
        end else begin
            r_sda_meta <= sda;
            r_sda_sync <= r_sda_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Phase counter in microsecond ticks, cleared on every state change.
    // w_elapsed includes the tick of the current cycle so that a phase that
    // has lasted N us compares as N on the cycle its end is observed.
    // ------------------------------------------------------------------------
    assign w_elapsed = r_cnt + {31'd0, w_tick};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (w_tick && (r_state != S_IDLE)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // High time at or above the threshold decodes as a 1.
    assign w_bit = (w_elapsed >= 32'(BIT_THRESH_US));

    // ------------------------------------------------------------------------
    // Checksum: last byte equals the 8-bit sum of the four preceding bytes.
    // Only meaningful for 40-bit frames.
    // ------------------------------------------------------------------------
    generate
        if (CHECKSUM_EN != 0) begin : g_checksum
            logic [7:0] w_sum;
            assign w_sum    = r_shift[39:32] + r_shift[31:24]
                            + r_shift[23:16] + r_shift[15:8];
            assign w_sum_ok = (w_sum == r_shift[7:0]);
        end else begin : g_no_checksum
            assign w_sum_ok = 1'b1;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_shift_en  = 1'b0;
        w_fail_load = 1'b0;
        w_fail_code = 2'd0;
        w_ok        = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (get) begin
                    w_next = S_START;
                end
            end

            S_START: begin
                if (w_elapsed >= 32'(START_LOW_US)) begin
                    w_next = S_RELEASE;
                end
            end

            // Right after release the synchronised value still reflects our
            // own low drive, so a sensor pull-down only counts once the line
            // has been seen high in this phase.
            S_RELEASE: begin
                if (r_seen_high && !r_sda_sync) begin
                    w_next = S_RESP_LOW;
                end else if (w_elapsed >= 32'(TIMEOUT_US)) begin
                    w_next      = S_FAIL;
                    w_fail_load = 1'b1;
                    w_fail_code = c_ERR_NORESP;
                end
            end

            S_RESP_LOW: begin
                if (r_sda_sync) begin
                    w_next = S_RESP_HIGH;
                end else if (w_elapsed >= 32'(TIMEOUT_US)) begin
                    w_next      = S_FAIL;
                    w_fail_load = 1'b1;
                    w_fail_code = c_ERR_NORESP;
                end
            end

            S_RESP_HIGH: begin
                if (!r_sda_sync) begin
                    w_next = S_BIT_LOW;
                end else if (w_elapsed >= 32'(TIMEOUT_US)) begin
                    w_next      = S_FAIL;
                    w_fail_load = 1'b1;
                    w_fail_code = c_ERR_NORESP;
                end
            end

            S_BIT_LOW: begin
                if (r_sda_sync) begin
                    w_next = S_BIT_HIGH;
                end else if (w_elapsed >= 32'(TIMEOUT_US)) begin
                    w_next      = S_FAIL;
                    w_fail_load = 1'b1;
                    w_fail_code = c_ERR_BITTO;
                end
            end

            // A falling edge ends the bit; it wins over a coincident timeout.
            S_BIT_HIGH: begin
                if (!r_sda_sync) begin
                    w_shift_en = 1'b1;
                    if (r_bitcnt == c_BIT_W'(NBITS - 1)) begin
                        w_next = S_CHECK;
                    end else begin
                        w_next = S_BIT_LOW;
                    end
                end else if (w_elapsed >= 32'(TIMEOUT_US)) begin
                    w_next      = S_FAIL;
                    w_fail_load = 1'b1;
                    w_fail_code = c_ERR_BITTO;
                end
            end

            S_CHECK: begin
                if (w_sum_ok) begin
                    w_ok   = 1'b1;
                    w_next = S_HOLD;
                end else begin
                    w_next      = S_FAIL;
                    w_fail_load = 1'b1;
                    w_fail_code = c_ERR_CSUM;
                end
            end

            S_FAIL: begin
                w_err  = 1'b1;
                w_next = S_HOLD;
            end

            S_HOLD: begin
                if (w_elapsed >= 32'(HOLDOFF_US)) begin
                    w_next = S_IDLE;
                end
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drive     <= 1'b0;
            r_seen_high <= 1'b0;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_fail_code <= 2'd0;
            data        <= '0;
            valid       <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            // Registered drive keeps the pin free of decode glitches.
            r_drive     <= (w_next == S_START);
            r_seen_high <= (r_state == S_RELEASE) && (r_seen_high || r_sda_sync);

            if (r_state == S_START) begin
                r_bitcnt <= '0;
            end else if (w_shift_en) begin
                r_bitcnt <= r_bitcnt + c_BIT_W'(1);
            end

            if (w_shift_en) begin
                r_shift <= {r_shift[NBITS-2:0], w_bit};
            end

            if (w_fail_load) begin
                r_fail_code <= w_fail_code;
            end

            valid <= w_ok;
            error <= w_err;

            if (w_ok) begin
                data     <= r_shift;
                err_code <= 2'd0;
            end else if (w_err) begin
                err_code <= r_fail_code;
            end
        end
    end

endmodule
`default_nettype wire
